// File: rtl/adaptive_pkg.sv
// Shared types, widths and saturation helpers for the adaptive FIR path.
// Contents:
//   NumTaps, SampleW, WeightW, AccW, ErrW : tap count and datapath widths
//   lms_state_e                           : coefficient-update FSM states
//   sat16 / sat20                         : signed clamps to 16 and 20 bits
package adaptive_pkg;

  localparam int unsigned NumTaps = 9;
  localparam int unsigned SampleW = 8;
  localparam int unsigned WeightW = 20;
  localparam int unsigned AccW    = 32;
  localparam int unsigned ErrW    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StUpd,
    StDone
  } lms_state_e;

  // Clamp a 33-bit signed value to [-32768, 32767].
  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767) begin
      return 16'sd32767;
    end else if (v < -33'sd32768) begin
      return -16'sd32768;
    end else begin
      return v[15:0];
    end
  endfunction

  // Clamp a 25-bit signed value to [-524288, 524287].
  function automatic logic signed [19:0] sat20(input logic signed [24:0] v);
    if (v > 25'sd524287) begin
      return 20'sd524287;
    end else if (v < -25'sd524288) begin
      return -20'sd524288;
    end else begin
      return v[19:0];
    end
  endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Combinational single-tap LMS update: h_new = sat20(h + ((err * x) >>> MU_SHIFT)).
// Shared across all taps by the top level through index muxing.
// Ports:
//   err   : latched, saturated error (s16)
//   x     : reference history sample for this tap (s8)
//   h     : current weight (s20)
//   h_new : updated, saturated weight (s20)
module lms_tap_mac
  import adaptive_pkg::*;
#(
  parameter int unsigned MU_SHIFT = 4
) (
  input  logic signed [ErrW-1:0]    err,
  input  logic signed [SampleW-1:0] x,
  input  logic signed [WeightW-1:0] h,
  output logic signed [WeightW-1:0] h_new
);

  logic signed [23:0] err_ext;
  logic signed [23:0] x_ext;
  logic signed [23:0] prod;
  logic signed [23:0] delta;
  logic signed [24:0] sum;

  assign err_ext = 24'(err);
  assign x_ext   = 24'(x);
  // 16x8 signed product always fits in 24 bits.
  assign prod    = err_ext * x_ext;
  assign delta   = prod >>> MU_SHIFT;
  // Summed wider than 21 bits so small MU_SHIFT values cannot wrap before the clamp.
  assign sum     = 25'(h) + 25'(delta);
  assign h_new   = sat20(sum);

endmodule

// File: rtl/lms_coef_update.sv
// LMS coefficient-update engine for the 9-tap adaptive FIR.
// Accepts one (ref_data, fir_out, desired) triple while idle, latches the saturated error
// and the freeze flag, then updates weights h0..h8 one per cycle with a shared MAC.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid, ref_data (s8), fir_out (s32), desired (s8), freeze : sample input
//   ready = !busy, busy : update in progress, done : one-cycle pulse, all taps final
//   h0..h8 (s20) : registered weights
module lms_coef_update
  import adaptive_pkg::*;
#(
  parameter int unsigned NTAPS     = NumTaps,
  parameter int unsigned FRAC      = 12,
  parameter int unsigned ERR_SHIFT = 12,
  parameter int unsigned MU_SHIFT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [SampleW-1:0] ref_data,
  input  logic signed [AccW-1:0]    fir_out,
  input  logic signed [SampleW-1:0] desired,
  input  logic                      freeze,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic signed [WeightW-1:0] h0,
  output logic signed [WeightW-1:0] h1,
  output logic signed [WeightW-1:0] h2,
  output logic signed [WeightW-1:0] h3,
  output logic signed [WeightW-1:0] h4,
  output logic signed [WeightW-1:0] h5,
  output logic signed [WeightW-1:0] h6,
  output logic signed [WeightW-1:0] h7,
  output logic signed [WeightW-1:0] h8
);

  localparam int unsigned IdxW = $clog2(NTAPS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NTAPS - 1);

  lms_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic accept;

  logic signed [SampleW-1:0] hist_q [NTAPS-1];
  logic signed [SampleW-1:0] snap_q [NTAPS];
  logic signed [WeightW-1:0] h_q    [NTAPS];
  logic signed [ErrW-1:0]    err_q, err_d;
  logic                      frz_q;

  logic signed [32:0]        des_ext, fir_ext, e_full, e_shift;
  logic signed [SampleW-1:0] x_sel;
  logic signed [WeightW-1:0] h_sel, h_new;

  // Error path: align desired to the FIR output's fixed point, then scale and clamp.
  assign des_ext = 33'(desired);
  assign fir_ext = 33'(fir_out);
  assign e_full  = (des_ext <<< FRAC) - fir_ext;
  assign e_shift = e_full >>> ERR_SHIFT;
  assign err_d   = sat16(e_shift);

  assign accept = (state_q == StIdle) && in_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StUpd;
          idx_d   = '0;
        end
      end
      StUpd: begin
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign x_sel = snap_q[idx_q];
  assign h_sel = h_q[idx_q];

  lms_tap_mac #(
    .MU_SHIFT(MU_SHIFT)
  ) u_tap_mac (
    .err  (err_q),
    .x    (x_sel),
    .h    (h_sel),
    .h_new(h_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      frz_q <= 1'b0;
      for (int i = 0; i < NTAPS - 1; i++) begin
        hist_q[i] <= '0;
      end
      for (int i = 0; i < NTAPS; i++) begin
        snap_q[i] <= '0;
        h_q[i]    <= '0;
      end
    end else begin
      if (accept) begin
        err_q     <= err_d;
        frz_q     <= freeze;
        // Snapshot pairs the new sample with the history as it stood before this shift.
        snap_q[0] <= ref_data;
        hist_q[0] <= ref_data;
        for (int k = 1; k < NTAPS; k++) begin
          snap_q[k] <= hist_q[k-1];
        end
        for (int k = 1; k < NTAPS - 1; k++) begin
          hist_q[k] <= hist_q[k-1];
        end
      end
      if ((state_q == StUpd) && !frz_q) begin
        h_q[idx_q] <= h_new;
      end
    end
  end

  assign busy  = (state_q != StIdle);
  assign ready = !busy;
  assign done  = (state_q == StDone);

  assign h0 = h_q[0];
  assign h1 = h_q[1];
  assign h2 = h_q[2];
  assign h3 = h_q[3];
  assign h4 = h_q[4];
  assign h5 = h_q[5];
  assign h6 = h_q[6];
  assign h7 = h_q[7];
  assign h8 = h_q[8];

endmodule
